// File: rtl/ppm_pkg.sv
// Shared PPM definitions: receiver FSM states, frame order codes common to
// transmitter and receiver, SLOT-derived frame geometry and small helpers.
package ppm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF1 = 3'd1,
    ST_GAP  = 3'd2,
    ST_SOF2 = 3'd3,
    ST_DATA = 3'd4,
    ST_EOF  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FRM_IDLE = 2'd0,
    FRM_SOF  = 2'd1,
    FRM_DATA = 2'd2,
    FRM_EOF  = 2'd3
  } frame_code_e;

  localparam int unsigned SLOT_CLKS_DEF = 32'd16;
  localparam int unsigned TOL_DEF       = 32'd4;
  localparam int unsigned NUM_SYMBOLS   = 32'd4;

  // Symbol window length (8 slots).
  function automatic int unsigned sym_len(input int unsigned slot);
    return 32'd8 * slot;
  endfunction

  // SOF preamble length: pulse, gap, pulse, guard up to the first symbol window.
  function automatic int unsigned sof_len(input int unsigned slot);
    return 32'd8 * slot;
  endfunction

  // EOF marker window length (4 slots).
  function automatic int unsigned eof_len(input int unsigned slot);
    return 32'd4 * slot;
  endfunction

  // Whole frame length measured from the SOF fall.
  function automatic int unsigned frame_len(input int unsigned slot);
    return sof_len(slot) + NUM_SYMBOLS * sym_len(slot) + eof_len(slot);
  endfunction

  // True when t lies within +/- tol of centre c.
  function automatic logic in_win(input int unsigned t, input int unsigned c,
                                  input int unsigned tol);
    return ((t + tol) >= c) && (t <= (c + tol));
  endfunction

  // Three-input majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ppm_decoder_rx_if.sv
// Byte-sink side of the PPM receiver: decoded byte, strobes and busy flag.
interface ppm_decoder_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (output data_out, output data_valid, output frame_err, output busy);
  modport slave  (input  data_out, input  data_valid, input  frame_err, input  busy);
endinterface

// File: rtl/ppm_rx_frontend.sv
// PPM line front end: 2-flop synchronizer, optional 3-sample majority filter
// (enabled by defining PPM_DEC_GLITCH_FILTER_EN) and registered fall/rise strobes.
// Latency from first low sample to fall strobe: 2 clocks, 4 with the filter.
module ppm_rx_frontend
  import ppm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic line_s;
  logic prev_q;
  logic fall_q;
  logic rise_q;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PPM_DEC_GLITCH_FILTER_EN
  logic hist1_q;
  logic hist2_q;
  logic maj_q;

  // Majority over three consecutive synchronized samples drops 1-cycle glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
      maj_q   <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      maj_q   <= maj3(sync2_q, hist1_q, hist2_q);
    end
  end

  assign line_s = maj_q;
`else
  assign line_s = sync2_q;
`endif

  // Previous-sample register and registered edge strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= line_s;
      fall_q <= prev_q & ~line_s;
      rise_q <= ~prev_q & line_s;
    end
  end

  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/ppm_decoder_rx.sv
// PPM receiver top: SOF detection, four 2-bit symbol windows timed against the
// SOF fall, EOF check, byte assembly and output strobes.
// Optional glitch filter in the front end: define PPM_DEC_GLITCH_FILTER_EN.
module ppm_decoder_rx
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_CLKS = 32'd16,
  parameter int unsigned TOL       = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Din,
  ppm_decoder_rx_if.master  rx_o
);

  localparam int unsigned TW = $clog2(frame_len(SLOT_CLKS));
  localparam int unsigned W8 = $clog2(sym_len(SLOT_CLKS));
  localparam int unsigned SH = $clog2(2 * SLOT_CLKS);

  localparam int unsigned C_SOF1 = SLOT_CLKS;
  localparam int unsigned C_GAP  = 5 * SLOT_CLKS;
  localparam int unsigned C_SOF2 = 6 * SLOT_CLKS;
  localparam int unsigned C_EOF  = 42 * SLOT_CLKS;

  localparam logic [TW-1:0] T_SOF1_HI  = TW'(C_SOF1 + TOL);
  localparam logic [TW-1:0] T_GAP_HI   = TW'(C_GAP + TOL);
  localparam logic [TW-1:0] T_SOF2_HI  = TW'(C_SOF2 + TOL);
  localparam logic [TW-1:0] T_DATA_LO  = TW'(sof_len(SLOT_CLKS));
  localparam logic [TW-1:0] T_DATA_END = TW'(sof_len(SLOT_CLKS) + NUM_SYMBOLS * sym_len(SLOT_CLKS) - 1);
  localparam logic [TW-1:0] T_EOF_HI   = TW'(C_EOF + TOL);
  localparam logic [TW-1:0] T_EOF_END  = TW'(frame_len(SLOT_CLKS) - 1);

  logic          fall_s;
  logic          rise_s;
  logic [31:0]   t32_s;
  logic [1:0]    sym_s;

  state_e        state_q;
  state_e        state_d;
  logic [TW-1:0] t_q;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic [1:0]    sym_cnt_q;
  logic [7:0]    byte_q;
  logic [7:0]    data_out_q;
  logic          data_valid_q;
  logic          frame_err_q;
  logic          busy_q;
  logic          err_d;
  logic          ok_d;
  logic          sym_wr_d;
  logic          win_end_d;

  ppm_rx_frontend u_frontend (
    .clk    (clk),
    .rst    (rst),
    .din_i  (Din),
    .fall_o (fall_s),
    .rise_o (rise_s)
  );

  assign t32_s = 32'(t_q);
  // Symbol value is the offset inside the window divided by two slots.
  assign sym_s = t_q[SH+1:SH];

  // Next-state, edge-window checks and per-window fall counting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    ok_d      = 1'b0;
    sym_wr_d  = 1'b0;
    win_end_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 2'd0;
        if (fall_s) state_d = ST_SOF1;
        else        state_d = ST_IDLE;
      end
      ST_SOF1: begin
        if (rise_s) begin
          if (in_win(t32_s, C_SOF1, TOL)) state_d = ST_GAP;
          else                             err_d   = 1'b1;
        end else if (t_q > T_SOF1_HI) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_SOF1;
        end
      end
      ST_GAP: begin
        if (fall_s) begin
          if (in_win(t32_s, C_GAP, TOL)) state_d = ST_SOF2;
          else                           err_d   = 1'b1;
        end else if (t_q > T_GAP_HI) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_SOF2: begin
        if (rise_s) begin
          if (in_win(t32_s, C_SOF2, TOL)) state_d = ST_DATA;
          else                            err_d   = 1'b1;
        end else if (t_q > T_SOF2_HI) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_SOF2;
        end
      end
      ST_DATA: begin
        if (t_q < T_DATA_LO) begin
          // Guard between SOF2 rise and the first symbol window: no falls allowed.
          if (fall_s) err_d   = 1'b1;
          else        state_d = ST_DATA;
        end else begin
          if (fall_s && (cnt_q == 2'd0)) sym_wr_d = 1'b1;
          else                           sym_wr_d = 1'b0;
          if (fall_s && (cnt_q != 2'd2)) cnt_d = cnt_q + 2'd1;
          else                           cnt_d = cnt_q;
          if (&t_q[W8-1:0]) begin
            win_end_d = 1'b1;
            if (cnt_d != 2'd1) err_d = 1'b1;
            else               err_d = 1'b0;
            cnt_d = 2'd0;
            if (t_q == T_DATA_END) state_d = ST_EOF;
            else                   state_d = ST_DATA;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_EOF: begin
        if (fall_s) begin
          if ((cnt_q == 2'd0) && in_win(t32_s, C_EOF, TOL)) cnt_d = 2'd1;
          else                                              err_d = 1'b1;
        end else if ((cnt_q == 2'd0) && (t_q > T_EOF_HI)) begin
          err_d = 1'b1;
        end else if (t_q == T_EOF_END) begin
          ok_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EOF;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (err_d) state_d = ST_IDLE;
    else       state_d = state_d;
  end

  // FSM state, frame timer, byte assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      t_q          <= '0;
      cnt_q        <= 2'd0;
      sym_cnt_q    <= 2'd0;
      byte_q       <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_valid_q <= ok_d;
      frame_err_q  <= err_d;
      busy_q       <= (state_d != ST_IDLE);
      if (state_d == ST_IDLE) t_q <= '0;
      else                    t_q <= t_q + TW'(1);
      if (state_q == ST_IDLE) begin
        byte_q    <= 8'h00;
        sym_cnt_q <= 2'd0;
      end else begin
        if (sym_wr_d)  byte_q[{sym_cnt_q, 1'b0} +: 2] <= sym_s;
        if (win_end_d) sym_cnt_q <= sym_cnt_q + 2'd1;
      end
      if (ok_d) data_out_q <= byte_q;
    end
  end

  assign rx_o.data_out   = data_out_q;
  assign rx_o.data_valid = data_valid_q;
  assign rx_o.frame_err  = frame_err_q;
  assign rx_o.busy       = busy_q;

endmodule
